// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one int_fp_mul among N_REQ valid/ready requesters.
// Define MODE_SWITCH_BUBBLE_EN to insert one idle cycle before any change of multiplier mode.
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_mode,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [N_REQ*DW-1:0] rsp_data,
  output logic                mul_mode,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic [DW-1:0]       mul_result,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]           pend_q, pend_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [N_REQ*DW-1:0]        rsp_buf_q, rsp_buf_d;
  logic                       mul_mode_q, mul_mode_d;
  logic [DW-1:0]              mul_a_q, mul_a_d;
  logic [DW-1:0]              mul_b_q, mul_b_d;
  logic [MUL_LAT-1:0]         tag_v_q, tag_v_d;
  logic [MUL_LAT-1:0][PW-1:0] tag_idx_q, tag_idx_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] rsp_fire;
  logic             grant_valid;
  logic [PW-1:0]    grant_idx;
  logic             stall;
  logic             issue;

  // A requester with a result still in flight or buffered is locked out until its response drains.
  assign eligible = req_valid & ~pend_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin : grant_scan
    logic [PW:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!grant_valid && eligible[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

`ifdef MODE_SWITCH_BUBBLE_EN
  logic last_mode_q, last_mode_d;
  logic bubble_q, bubble_d;

  // The idle cycle is spent once; the following cycle issues even though the mode still differs.
  assign stall       = grant_valid && (req_mode[grant_idx] != last_mode_q) && !bubble_q;
  assign bubble_d    = stall;
  assign last_mode_d = issue ? req_mode[grant_idx] : last_mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_mode_q <= 1'b0;
      bubble_q    <= 1'b0;
    end else begin
      last_mode_q <= last_mode_d;
      bubble_q    <= bubble_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Gating with reset keeps req_ready low while the design is held in reset.
  assign issue = grant_valid & ~stall & reset;

  always_comb begin : ready_decode
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin : next_state
    rr_ptr_d   = rr_ptr_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_mode_d = mul_mode_q;
    if (issue) begin
      mul_a_d    = req_a[grant_idx*DW +: DW];
      mul_b_d    = req_b[grant_idx*DW +: DW];
      mul_mode_d = req_mode[grant_idx];
      rr_ptr_d   = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end

    tag_v_d      = tag_v_q;
    tag_idx_d    = tag_idx_q;
    tag_v_d[0]   = issue;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    pend_d = (pend_q & ~rsp_fire) | req_ready;

    // Capture and handshake can never hit the same index: pend blocks a second operation.
    rsp_valid_d = rsp_valid_q & ~rsp_fire;
    rsp_buf_d   = rsp_buf_q;
    if (tag_v_q[MUL_LAT-1]) begin
      rsp_valid_d[tag_idx_q[MUL_LAT-1]]          = 1'b1;
      rsp_buf_d[tag_idx_q[MUL_LAT-1]*DW +: DW] = mul_result;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      pend_q      <= '0;
      rsp_valid_q <= '0;
      // NOTE: the response buffers are reset because they drive rsp_data, which must read zero in reset.
      rsp_buf_q   <= '0;
      mul_mode_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_buf_q   <= rsp_buf_d;
      mul_mode_q  <= mul_mode_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_buf_q;
  assign mul_mode  = mul_mode_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (|tag_v_q) | (|rsp_valid_q);

endmodule
